// File: rtl/sync_ram_pkg.sv
// Shared types and constants for the sync_ram slice.
// Optional macro SYNC_RAM_BYTE_EN enables per-byte write masking.
package sync_ram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int nbytes(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/sync_ram_array.sv
// Word-addressed storage with async read and clocked write.
// SYNC_RAM_BYTE_EN selects byte-masked writes; otherwise full words.
module sync_ram_array
  import sync_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / BYTE_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[raddr];

`ifdef SYNC_RAM_BYTE_EN
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[waddr][i*BYTE_W +: BYTE_W] <=
            wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end
`else
  logic unused_be;
  assign unused_be = ^be;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end
`endif

endmodule

// File: rtl/sync_ram.sv
// Single-port RAM with power-on clear and valid/ready handshake.
// SYNC_RAM_BYTE_EN (in sync_ram_array) enables byte-masked writes.
module sync_ram
  import sync_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                    Clock,
  input  logic                    ResetN,
  input  logic                    ReqValid,
  output logic                    ReqReady,
  input  logic                    ReadWrite,
  input  logic [ADDR_WIDTH-1:0]   Address,
  input  logic [DATA_WIDTH-1:0]   DataIn,
  input  logic [DATA_WIDTH/8-1:0] ByteEn,
  output logic                    RespValid,
  input  logic                    RespReady,
  output logic [DATA_WIDTH-1:0]   DataOut,
  output logic                    InitDone
);

  localparam int NB = DATA_WIDTH / 8;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_d;

  logic                  run;
  logic                  accept;
  logic                  rd_acc;
  logic                  wr_acc;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NB-1:0]         mem_be;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  vld_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  assign run      = (state_q == RUN);
  assign InitDone = run;
  assign ReqReady = run && (!vld_q || RespReady);
  assign accept   = ReqValid && ReqReady;
  assign rd_acc   = accept && ReadWrite;
  assign wr_acc   = accept && !ReadWrite;

  // Clearing shares the write port; a reset edge blocks every write.
  assign mem_we    = ResetN && (!run || wr_acc);
  assign mem_waddr = run ? Address : cnt_q;
  assign mem_wdata = run ? DataIn : '0;
  assign mem_be    = run ? ByteEn : '1;

  sync_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (Clock),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .be    (mem_be),
    .raddr (Address),
    .rdata (mem_rdata)
  );

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (rd_acc) begin
      vld_q  <= 1'b1;
      data_q <= mem_rdata;
    end else if (RespReady) begin
      vld_q  <= 1'b0;
    end
  end

  assign RespValid = vld_q;
  assign DataOut   = data_q;

endmodule

// File: tb/tb_sync_ram.sv
// Directed bench for sync_ram (ADDR_WIDTH 4, DATA_WIDTH 32).
// Expected byte-enable results follow SYNC_RAM_BYTE_EN.
module tb_sync_ram;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          Clock;
  logic          ResetN;
  logic          ReqValid;
  logic          ReqReady;
  logic          ReadWrite;
  logic [AW-1:0] Address;
  logic [DW-1:0] DataIn;
  logic [3:0]    ByteEn;
  logic          RespValid;
  logic          RespReady;
  logic [DW-1:0] DataOut;
  logic          InitDone;

  int checks = 0;
  int errors = 0;

  sync_ram #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .Clock     (Clock),
    .ResetN    (ResetN),
    .ReqValid  (ReqValid),
    .ReqReady  (ReqReady),
    .ReadWrite (ReadWrite),
    .Address   (Address),
    .DataIn    (DataIn),
    .ByteEn    (ByteEn),
    .RespValid (RespValid),
    .RespReady (RespReady),
    .DataOut   (DataOut),
    .InitDone  (InitDone)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic rw, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [3:0] be);
    ReqValid  = 1'b1;
    ReadWrite = rw;
    Address   = a;
    DataIn    = d;
    ByteEn    = be;
  endtask

  logic [DW-1:0] exp_be1;
  logic [DW-1:0] exp_be0;
  int            n;

  initial begin
`ifdef SYNC_RAM_BYTE_EN
    exp_be1 = 32'h00BB00DD;
    exp_be0 = 32'h00BB00DD;
`else
    exp_be1 = 32'hAABBCCDD;
    exp_be0 = 32'h12345678;
`endif
    ResetN    = 1'b0;
    ReqValid  = 1'b0;
    ReadWrite = 1'b0;
    Address   = '0;
    DataIn    = '0;
    ByteEn    = '0;
    RespReady = 1'b1;
    tick();
    tick();
    chk("rst_respvalid", 32'(RespValid), 32'd0);
    chk("rst_dataout", DataOut, 32'd0);
    chk("rst_initdone", 32'(InitDone), 32'd0);
    chk("rst_reqready", 32'(ReqReady), 32'd0);

    // Release reset; a write offered during clear must be ignored.
    ResetN = 1'b1;
    req(1'b0, 4'd5, 32'hFFFFFFFF, 4'hF);
    #1;
    chk("init_ready0", 32'(ReqReady), 32'd0);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("init_ready", 32'(ReqReady), 32'd0);
      chk("init_done0", 32'(InitDone), 32'd0);
    end
    ReqValid = 1'b0;
    tick();
    chk("init_done1", 32'(InitDone), 32'd1);
    chk("run_ready", 32'(ReqReady), 32'd1);

    req(1'b1, 4'd5, 32'h0, 4'hF);
    tick();
    ReqValid = 1'b0;
    chk("rd5_valid", 32'(RespValid), 32'd1);
    chk("rd5_data", DataOut, 32'h0);

    req(1'b0, 4'd3, 32'hDEADBEEF, 4'hF);
    tick();
    chk("wr_noresp", 32'(RespValid), 32'd0);
    req(1'b1, 4'd3, 32'h0, 4'hF);
    tick();
    chk("raw_valid", 32'(RespValid), 32'd1);
    chk("raw_data", DataOut, 32'hDEADBEEF);

    // Stall: response held while consumer is not ready.
    req(1'b1, 4'd2, 32'h0, 4'hF);
    RespReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ready", 32'(ReqReady), 32'd0);
      tick();
      chk("hold_valid", 32'(RespValid), 32'd1);
      chk("hold_data", DataOut, 32'hDEADBEEF);
    end
    RespReady = 1'b1;
    #1;
    chk("release_ready", 32'(ReqReady), 32'd1);
    tick();
    ReqValid = 1'b0;
    chk("release_data", DataOut, 32'h0);

    req(1'b0, 4'd1, 32'h11111111, 4'hF);
    tick();
    req(1'b0, 4'd2, 32'h22222222, 4'hF);
    tick();
    req(1'b1, 4'd1, 32'h0, 4'hF);
    tick();
    chk("b2b1_valid", 32'(RespValid), 32'd1);
    chk("b2b1_data", DataOut, 32'h11111111);
    req(1'b1, 4'd2, 32'h0, 4'hF);
    tick();
    chk("b2b2_valid", 32'(RespValid), 32'd1);
    chk("b2b2_data", DataOut, 32'h22222222);
    req(1'b1, 4'd3, 32'h0, 4'hF);
    tick();
    chk("b2b3_valid", 32'(RespValid), 32'd1);
    chk("b2b3_data", DataOut, 32'hDEADBEEF);
    ReqValid = 1'b0;
    tick();
    chk("drain_valid", 32'(RespValid), 32'd0);
    chk("drain_keep", DataOut, 32'hDEADBEEF);

    req(1'b0, 4'd7, 32'hAABBCCDD, 4'b0101);
    tick();
    req(1'b1, 4'd7, 32'h0, 4'hF);
    tick();
    chk("be_data", DataOut, exp_be1);
    req(1'b0, 4'd7, 32'h12345678, 4'b0000);
    tick();
    req(1'b1, 4'd7, 32'h0, 4'hF);
    tick();
    chk("be0_data", DataOut, exp_be0);

    // Reset while a response is pending.
    req(1'b1, 4'd3, 32'h0, 4'hF);
    RespReady = 1'b0;
    tick();
    ReqValid = 1'b0;
    chk("pend_valid", 32'(RespValid), 32'd1);
    ResetN = 1'b0;
    tick();
    chk("rst2_valid", 32'(RespValid), 32'd0);
    chk("rst2_data", DataOut, 32'h0);
    chk("rst2_done", 32'(InitDone), 32'd0);
    chk("rst2_ready", 32'(ReqReady), 32'd0);
    ResetN    = 1'b1;
    RespReady = 1'b1;
    n = 0;
    while (!InitDone && n < 40) begin
      tick();
      n++;
    end
    chk("reinit_cycles", 32'(n), 32'd16);
    req(1'b1, 4'd3, 32'h0, 4'hF);
    tick();
    ReqValid = 1'b0;
    chk("reinit_valid", 32'(RespValid), 32'd1);
    chk("reinit_data", DataOut, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
